// File: rtl/reset_sequencer.sv
// Chip-level reset sequencer: merges masked reset sources and PLL lock, stretches each reset
// event, releases the outputs in order and keeps a sticky cause vector. Optional watchdog: RSTSEQ_WATCHDOG_EN.
module reset_sequencer #(
    parameter int unsigned NUM_SRC        = 4,
    parameter int unsigned NUM_OUT        = 3,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned STRETCH_CYCLES = 16,
    parameter int unsigned STEP_CYCLES    = 8,
    parameter int unsigned WDT_CYCLES     = 65536
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [NUM_SRC-1:0] RstSrc,
    input  logic [NUM_SRC-1:0] SrcMask,
    input  logic               LockIn,
    input  logic               Kick,
    input  logic               CauseClr,
    output logic [NUM_OUT-1:0] RstOut,
    output logic               Ready,
    output logic [NUM_SRC+1:0] Cause
);

    localparam int unsigned CntW  = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
    localparam int unsigned StepW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned KW    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [CntW-1:0]  CntLoad  = CntW'(STRETCH_CYCLES - 1);
    localparam logic [StepW-1:0] StepLoad = StepW'(STEP_CYCLES - 1);
    // Index of the last output released while still in RELEASE; the final one releases into RUN.
    localparam logic [KW-1:0]    KLast    = KW'((NUM_OUT > 1) ? NUM_OUT - 2 : 0);

    typedef enum logic [1:0] {StAssert, StWaitLock, StRelease, StRun} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [StepW-1:0]   step_q, step_d;
    logic [KW-1:0]      k_q, k_d;
    logic [NUM_SRC+1:0] cause_q, cause_d;

    logic [NUM_SRC-1:0]     src_sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] lock_sync_q;

    logic [NUM_SRC-1:0] req_vec;
    logic               req;
    logic               lk;
    logic               lock_loss;
    logic               wdt_expire;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) src_sync_q[i] <= '0;
            lock_sync_q <= '0;
        end else begin
            src_sync_q[0] <= RstSrc;
            for (int i = 1; i < SYNC_STAGES; i++) src_sync_q[i] <= src_sync_q[i-1];
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], LockIn};
        end
    end

    assign req_vec = src_sync_q[SYNC_STAGES-1] & SrcMask;
    assign req     = |req_vec;
    assign lk      = lock_sync_q[SYNC_STAGES-1];

`ifdef RSTSEQ_WATCHDOG_EN
    localparam int unsigned    WdtW    = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [WdtW-1:0] WdtLast = WdtW'(WDT_CYCLES - 1);

    logic [WdtW-1:0] wdt_q, wdt_d;

    // A kick on the expiry cycle wins over the timeout.
    assign wdt_expire = (state_q == StRun) && !Kick && (wdt_q == WdtLast);

    always_comb begin
        wdt_d = wdt_q;
        if (state_q != StRun || Kick) begin
            wdt_d = '0;
        end else if (wdt_q != WdtLast) begin
            wdt_d = wdt_q + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) wdt_q <= '0;
        else       wdt_q <= wdt_d;
    end
`else
    localparam int unsigned UnusedWdtCycles = WDT_CYCLES;
    logic unused_kick;
    assign unused_kick = Kick;
    assign wdt_expire  = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StAssert;
            cnt_q   <= CntLoad;
            step_q  <= StepLoad;
            k_q     <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            k_q     <= k_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        step_d    = step_q;
        k_d       = k_q;
        lock_loss = 1'b0;
        unique case (state_q)
            StAssert: begin
                if (req)               cnt_d   = CntLoad;
                else if (cnt_q == '0)  state_d = StWaitLock;
                else                   cnt_d   = cnt_q - 1'b1;
            end
            StWaitLock: begin
                if (lk) begin
                    state_d = StRelease;
                    k_d     = '0;
                    step_d  = StepLoad;
                end
            end
            StRelease: begin
                if (NUM_OUT == 1) begin
                    state_d = StRun;
                end else if (step_q == '0) begin
                    if (k_q == KLast) begin
                        state_d = StRun;
                    end else begin
                        k_d    = k_q + 1'b1;
                        step_d = StepLoad;
                    end
                end else begin
                    step_d = step_q - 1'b1;
                end
            end
            StRun: ;
            default: state_d = StAssert;
        endcase

        if (!lk && (state_q == StRelease || state_q == StRun)) lock_loss = 1'b1;
        if (req || lock_loss || wdt_expire) begin
            state_d = StAssert;
            cnt_d   = CntLoad;
        end

        // Sets take priority over a simultaneous clear.
        cause_d = (cause_q & ~{(NUM_SRC + 2){CauseClr}}) | {wdt_expire, lock_loss, req_vec};
    end

    always_comb begin
        RstOut = '1;
        Ready  = 1'b0;
        unique case (state_q)
            StRelease: begin
                for (int i = 0; i < NUM_OUT; i++) RstOut[i] = (i > int'(k_q));
            end
            StRun: begin
                RstOut = '0;
                Ready  = 1'b1;
            end
            default: ;
        endcase
    end

    assign Cause = cause_q;

endmodule
